// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the iterative AES-128 engine.
package aes_pkg;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned RND_W     = 4;

    typedef logic [BLK_W-1:0] blk_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Key-schedule round constant; index 0 is never used by the sequencer.
    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_iter_ctrl_if.sv
// Block-level plaintext/key input and ciphertext output handshakes.
interface aes_iter_ctrl_if;
    import aes_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t in_data;
    blk_t in_key;
    logic out_valid;
    logic out_ready;
    blk_t out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current one.
module aes_key_step
    import aes_pkg::*;
(
    input  blk_t       key_i,
    input  logic [7:0] rcon_i,
    output blk_t       key_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (rot_w[8*i +: 8]),
            .byte_o (sub_w[8*i +: 8])
        );
    end

    assign n0    = w0 ^ sub_w ^ {rcon_i, 24'h000000};
    assign n1    = w1 ^ n0;
    assign n2    = w2 ^ n1;
    assign n3    = w3 ^ n2;
    assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table.
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry k sits at bit offset 8*(255-k), which is 8 * ~k.
    assign byte_o = SBOX_TBL[{~byte_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 sequencer: FSM, round counter, state/key registers and handshakes.
// The round function itself lives in an external single-round datapath.
module aes_iter_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128
) (
    input  logic           clk,
    input  logic           rst,
    aes_iter_ctrl_if.slave bus,
    output blk_t           rnd_state_o,
    output blk_t           rnd_key_o,
    output logic           rnd_last_o,
    input  blk_t           rnd_state_i,
    output logic           busy
);
    if (NR != NR_AES128) begin : g_nr_check
        $error("aes_iter_ctrl supports only NR = 10 (AES-128)");
    end

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);

    logic [1:0]       state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    blk_t             data_q, data_d;
    blk_t             key_q, key_d;
    blk_t             next_key;
    logic [7:0]       rcon_cur;
    logic             in_ready_q, out_valid_q, busy_q;
    logic             in_round;

    assign rcon_cur = rcon(round_q);

    aes_key_step u_key_step (
        .key_i  (key_q),
        .rcon_i (rcon_cur),
        .key_o  (next_key)
    );

    // Next-state logic for FSM, counter and the state/key registers.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d  = bus.in_data ^ bus.in_key;
                    key_d   = bus.in_key;
                    round_d = RND_W'(1);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                data_d = rnd_state_i;
                key_d  = next_key;
                if (round_q == RND_LAST) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + RND_W'(1);
                end
            end
            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            data_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            data_q      <= data_d;
            key_q       <= key_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_ROUND) || (state_d == S_DONE);
        end
    end

    assign in_round = (state_q == S_ROUND);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = data_q;
    assign busy          = busy_q;

    assign rnd_state_o = in_round ? data_q : '0;
    assign rnd_key_o   = in_round ? next_key : '0;
    assign rnd_last_o  = in_round && (round_q == RND_LAST);

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: behavioural AES round as the datapath, FIPS-197 vectors,
// scoreboard of expected ciphertexts and a cycle-level model of the handshake timing.
module tb_aes_iter_ctrl;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] rnd_state_o, rnd_key_o, rnd_state_i;
    logic         rnd_last_o, busy;

    aes_iter_ctrl_if bus ();

    aes_iter_ctrl #(.NR(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rnd_state_o (rnd_state_o),
        .rnd_key_o   (rnd_key_o),
        .rnd_last_o  (rnd_last_o),
        .rnd_state_i (rnd_state_i),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    vec_t vecs[2];
    vec_t sb[$];
    int   cur_vec    = 0;
    int   exp_rnd    = 0;
    int   last_cnt   = 0;
    int   acc_edge   = 0;
    bit   ov_seen    = 1'b0;
    bit   b2b        = 1'b0;
    int   prev_acc   = -1;
    int   n_dut_out  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference round: GF(2^8) inverse + affine S-box, ShiftRows, MixColumns.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) b[i] = ref_sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
        return res;
    endfunction

    always_comb rnd_state_i = ref_round(rnd_state_o, rnd_key_o, rnd_last_o);

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cycle-level expectation of the handshake/round timing plus scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_rnd  = 0;
            last_cnt = 0;
            sb.delete();
        end else begin
            check("busy",      128'(busy),          128'(exp_rnd != 0));
            check("in_ready",  128'(bus.in_ready),  128'(exp_rnd == 0));
            check("out_valid", 128'(bus.out_valid), 128'(exp_rnd == 11));
            check("rnd_last",  128'(rnd_last_o),    128'(exp_rnd == 10));
            if (rnd_last_o) last_cnt++;
            if (sb.size() > 0) begin
                if (exp_rnd == 1)  check("rnd_key_r1",  rnd_key_o, sb[0].rk1);
                if (exp_rnd == 10) check("rnd_key_r10", rnd_key_o, sb[0].rk10);
                if (exp_rnd == 11) check("out_data",    bus.out_data, sb[0].ct);
            end
            if (bus.out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                check("latency", 128'(cyc - acc_edge), 128'(10));
            end
            if (bus.out_valid && bus.out_ready) n_dut_out++;

            if (exp_rnd == 11) begin
                if (bus.out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    check("last_per_block", 128'(last_cnt), 128'(1));
                    exp_rnd = 0;
                end
            end else if (exp_rnd != 0) begin
                exp_rnd++;
            end else if (bus.in_valid) begin
                sb.push_back(vecs[cur_vec]);
                if (b2b && prev_acc >= 0) check("b2b_gap", 128'(cyc - prev_acc), 128'(12));
                prev_acc = cyc;
                acc_edge = cyc + 1;
                ov_seen  = 1'b0;
                last_cnt = 0;
                exp_rnd  = 1;
            end
        end
    end

    task automatic drive_vec(input int v);
        cur_vec      = v;
        bus.in_data  = vecs[v].pt;
        bus.in_key   = vecs[v].key;
        bus.in_valid = 1'b1;
    endtask

    // Returns #1 after the accept edge.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (exp_rnd == 0 && sb.size() == 0) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic garble_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        vecs[0] = '{pt:   128'h3243f6a8885a308d313198a2e0370734,
                    key:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:   128'h3925841d02dc09fbdc118597196a0b32,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{pt:   128'h00112233445566778899aabbccddeeff,
                    key:  128'h000102030405060708090a0b0c0d0e0f,
                    ct:   128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    rk1:  128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                    rk10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy",      128'(busy),          128'(0));
        check("rst_rnd_last",  128'(rnd_last_o),    128'(0));
        check("rst_out_data",  bus.out_data,        128'(0));
        check("rst_rnd_key",   rnd_key_o,           128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;

        // App. B with out_ready high throughout, inputs scrambled after accept.
        bus.out_ready = 1'b1;
        drive_vec(0);
        wait_accept();
        garble_inputs();
        wait_idle();

        // App. C with 7+ cycles of backpressure; a new block is offered during DONE.
        bus.out_ready = 1'b0;
        drive_vec(1);
        wait_accept();
        garble_inputs();
        for (int i = 0; i < 30 && !bus.out_valid; i++) @(negedge clk);
        @(posedge clk); #1;
        drive_vec(0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_out_data",  bus.out_data,        vecs[1].ct);
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_accept();
        garble_inputs();
        wait_idle();

        // Reset in round 5 aborts the block; then App. B runs cleanly.
        drive_vec(1);
        wait_accept();
        garble_inputs();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_busy",      128'(busy),          128'(0));
        check("abort_rnd_last",  128'(rnd_last_o),    128'(0));
        check("abort_rnd_state", rnd_state_o,         128'(0));
        check("abort_out_data",  bus.out_data,        128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        drive_vec(0);
        wait_accept();
        garble_inputs();
        wait_idle();

        // Back-to-back blocks with in_valid held high.
        b2b      = 1'b1;
        prev_acc = -1;
        drive_vec(0);
        wait_accept();
        drive_vec(1);
        wait_accept();
        garble_inputs();
        wait_idle();
        b2b = 1'b0;

        check("blocks_out", 128'(n_dut_out), 128'(6));
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
- Sequencer for an iterative AES-128 encryption engine that reuses one external single-round datapath ten times per block.
- Accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey.
- Generates round keys on the fly and steers the datapath each cycle, then presents the ciphertext over a valid/ready output handshake.
- Sits between the top-level AES wrapper (plaintext/cipher-key/output ports) and the round datapath.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  plaintext and key valid
- in_ready  out  1  controller can accept a block
- in_data  in  128  plaintext, byte 0 in bits [127:120]
- in_key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext
- rnd_state_o  out  128  state to the round datapath
- rnd_key_o  out  128  round key for the current round
- rnd_last_o  out  1  final round; datapath skips MixColumns
- rnd_state_i  in  128  combinational round result from the datapath
- busy  out  1  high in ROUND or DONE

Behaviour:
- Reset is asynchronous and active-high:
  - state=IDLE; state_reg, key_reg, out_data = 0; round = 0.
  - in_ready = 1 after reset release; out_valid = 0; busy = 0; rnd_last_o = 0.
- IDLE: in_ready = 1.
  - On in_valid & in_ready at edge E0: state_reg <= in_data ^ in_key; key_reg <= in_key; round <= 1; go to ROUND.
- ROUND (in_ready = 0):
  - next_key = key_step(key_reg, rcon[round]), combinational.
  - rnd_state_o = state_reg; rnd_key_o = next_key; rnd_last_o = (round == NR).
  - At each edge: state_reg <= rnd_state_i; key_reg <= next_key.
  - If round == NR: go to DONE. Otherwise round <= round + 1.
- DONE:
  - out_valid = 1; out_data = state_reg, held stable while out_ready = 0.
  - On out_valid & out_ready: go to IDLE, round <= 0. in_ready rises the following cycle; there is no same-cycle accept of the next block.
- Latency: out_valid first high in the cycle after edge E0+NR, i.e. 10 clocks after the input handshake. Throughput: one block per 12 cycles minimum.
- Round counter: 4 bits, values 1..10. It never wraps and never exceeds NR.
- Input is ignored outside IDLE; in_data and in_key may change freely once accepted.
- out_ready held high before DONE has no effect.
- rnd_* outputs are don't-care outside ROUND and are driven to 0 there for determinism.
- Reset asserted mid-ROUND or mid-DONE aborts immediately: the block is discarded and no out_valid pulse occurs.
- Illegal FSM encoding returns to IDLE.

Decomposition:
- Package aes_pkg:
  - rcon constants (01,02,04,08,10,20,40,80,1b,36) indexed by round.
  - FSM state encoding IDLE/ROUND/DONE.
  - NR_AES128 = 10.
  - Block/key width constant 128.
- Sub-module aes_key_step (combinational):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Uses 4 S-box instances.
- The controller holds only the FSM, counter, state/key registers and handshakes.

Test Plan:
- FIPS-197 App. B: in_data 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, bench reference round model as datapath -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after the accept edge.
- FIPS-197 App. C.1: in_data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a. During round 10, rnd_key_o = 13111d7fe3944a17f307a78b4d2b30c5.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_valid and out_data stable. in_ready=0 and new in_valid ignored until the cycle after out_ready=1.
- rnd_last_o check -> high in exactly one cycle per block, when round=10. rnd_key_o in round 1 for App. B key = a0fafe1788542cb123a339392a6c7605.
- Reset asserted at round 5 -> all outputs at reset values asynchronously, in_ready=1 after release. A subsequent App. B block yields the correct ciphertext.
- Back-to-back: two blocks issued with in_valid held high -> two correct outputs, accept edges 12 cycles apart with out_ready=1.
